// File: rtl/ic_bram_cpu_bus_bridge.sv
// BRAM-style master port to CPU request/response bus bridge, one transaction in flight.
// Optional grant-wait timeout enabled by defining IC_BRAM_BUS_BRIDGE_TIMEOUT_EN.
module ic_bram_cpu_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        bram_cen,
  input  logic [31:0] bram_addr,
  input  logic [31:0] bram_wdata,
  input  logic [3:0]  bram_wstrb,
  output logic        bram_stall,
  output logic [31:0] bram_rdata,
  output logic        bram_error,
  input  logic        err_clr,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_wen,
  output logic [3:0]  mem_strb,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  input  logic        mem_recv,
  output logic        mem_ack,
  input  logic        mem_error,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        rsp_take;
  logic        timeout_hit;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..65535");
  end

  assign rsp_take = (state == RSP) && mem_recv;

`ifdef IC_BRAM_BUS_BRIDGE_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // REQ is only entered from IDLE, so clearing in IDLE clears on every entry.
  assign timeout_hit = (state == REQ) && !mem_gnt &&
                       (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else if (state == REQ && !mem_gnt) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bram_rdata <= '0;
      bram_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bram_cen) begin
        addr_q  <= bram_addr;
        wdata_q <= bram_wdata;
        wstrb_q <= bram_wstrb;
      end
      if (rsp_take) begin
        bram_rdata <= mem_rdata;
      end else if (timeout_hit) begin
        bram_rdata <= '0;
      end
      // A new error in the same cycle as a clear must not be lost.
      if ((rsp_take && mem_error) || timeout_hit) begin
        bram_error <= 1'b1;
      end else if (err_clr) begin
        bram_error <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bram_cen) state_nxt = REQ;
      REQ: begin
        if (mem_gnt) state_nxt = RSP;
        else if (timeout_hit) state_nxt = DONE;
      end
      RSP:  if (mem_recv) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req    = (state == REQ);
    mem_ack    = (state == RSP);
    mem_wen    = 1'b0;
    mem_strb   = '0;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    bram_stall = bram_cen && (state != DONE);
    if (state == REQ) begin
      mem_wen  = |wstrb_q;
      mem_strb = wstrb_q;
    end
  end

endmodule

// File: tb/tb_ic_bram_cpu_bus_bridge.sv
// Directed bench for ic_bram_cpu_bus_bridge; timeout scenario follows IC_BRAM_BUS_BRIDGE_TIMEOUT_EN.
module tb_ic_bram_cpu_bus_bridge;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        bram_cen;
  logic [31:0] bram_addr;
  logic [31:0] bram_wdata;
  logic [3:0]  bram_wstrb;
  logic        bram_stall;
  logic [31:0] bram_rdata;
  logic        bram_error;
  logic        err_clr;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_wen;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic        mem_recv;
  logic        mem_ack;
  logic        mem_error;
  logic [31:0] mem_rdata;

  int checks = 0;
  int passed = 0;

  int          r_wait, h_bad, r_bad, d_lat;
  logic [31:0] a_seen, d_seen;
  logic [3:0]  s_seen;
  logic        w_seen;

  ic_bram_cpu_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .bram_cen(bram_cen), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_wstrb(bram_wstrb), .bram_stall(bram_stall), .bram_rdata(bram_rdata),
    .bram_error(bram_error), .err_clr(err_clr),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_recv(mem_recv),
    .mem_ack(mem_ack), .mem_error(mem_error), .mem_rdata(mem_rdata)
  );

  // clock / reset
  always #5 g_clk = ~g_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  // driver: one full transaction, ending in the acceptance cycle with cen still high
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input int gnt_wait, input int rsp_wait, input logic [31:0] rd,
                         input logic er, input bit glitch, input bit clr_at_recv);
    h_bad = 0; r_bad = 0; a_seen = '0; d_seen = '0; s_seen = '0; w_seen = 1'b0;
    bram_cen = 1'b1; bram_addr = a; bram_wdata = wd; bram_wstrb = ws;
    r_wait = 0;
    do begin
      step();
      r_wait++;
    end while (mem_req !== 1'b1 && r_wait < 10);
    if (mem_req !== 1'b1) r_wait = -1;
    for (int i = 0; i <= gnt_wait; i++) begin
      if (mem_req !== 1'b1 || mem_addr !== a || mem_wdata !== wd || mem_strb !== ws ||
          mem_wen !== (|ws) || mem_ack !== 1'b0 || bram_stall !== 1'b1) h_bad++;
      a_seen = mem_addr; d_seen = mem_wdata; s_seen = mem_strb; w_seen = mem_wen;
      mem_gnt = (i == gnt_wait);
      if (glitch && i == 0 && gnt_wait > 0) begin
        mem_recv = 1'b1; mem_rdata = 32'hBAD0_BAD0; mem_error = 1'b1;
      end
      step();
      mem_gnt = 1'b0; mem_recv = 1'b0; mem_error = 1'b0; mem_rdata = '0;
    end
    for (int i = 0; i <= rsp_wait; i++) begin
      if (mem_ack !== 1'b1 || mem_req !== 1'b0 || mem_wen !== 1'b0 ||
          mem_strb !== 4'b0 || bram_stall !== 1'b1) r_bad++;
      if (i == rsp_wait) begin
        mem_recv = 1'b1; mem_rdata = rd; mem_error = er; err_clr = clr_at_recv;
      end
      step();
      mem_recv = 1'b0; mem_error = 1'b0; err_clr = 1'b0; mem_rdata = '0;
    end
    d_lat = 1;
    while (bram_stall !== 1'b0 && d_lat < 10) begin
      step();
      d_lat++;
    end
    if (bram_stall !== 1'b0) d_lat = -1;
  endtask

  task automatic test_reset();
    g_reset = 1'b1; bram_cen = 1'b0; bram_addr = '0; bram_wdata = '0; bram_wstrb = '0;
    err_clr = 1'b0; mem_gnt = 1'b0; mem_recv = 1'b0; mem_error = 1'b0; mem_rdata = '0;
    step(); step();
    g_reset = 1'b0;
    step();
    checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got=%b exp=0", mem_req); else passed++;
    checks++; if (mem_ack !== 1'b0) $display("FAIL reset_mem_ack got=%b exp=0", mem_ack); else passed++;
    checks++; if (bram_rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", bram_rdata); else passed++;
    checks++; if (bram_error !== 1'b0) $display("FAIL reset_error got=%b exp=0", bram_error); else passed++;
    checks++; if (bram_stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", bram_stall); else passed++;
    checks++; if (mem_wen !== 1'b0 || mem_strb !== 4'b0) $display("FAIL reset_wen_strb got=%b/%b exp=0/0", mem_wen, mem_strb); else passed++;
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) $display("FAIL reset_latches got=%h/%h exp=0/0", mem_addr, mem_wdata); else passed++;
  endtask

  task automatic test_read_zero_wait();
    bram_cen = 1'b1; bram_addr = 32'h0000_1000; bram_wstrb = 4'b0; bram_wdata = 32'hFFFF_0000;
    #1;
    checks++; if (bram_stall !== 1'b1) $display("FAIL rd0_stall_c0 got=%b exp=1", bram_stall); else passed++;
    step();
    checks++; if (mem_req !== 1'b1) $display("FAIL rd0_req_c1 got=%b exp=1", mem_req); else passed++;
    checks++; if (mem_wen !== 1'b0) $display("FAIL rd0_wen got=%b exp=0", mem_wen); else passed++;
    checks++; if (mem_addr !== 32'h0000_1000) $display("FAIL rd0_addr got=%h exp=00001000", mem_addr); else passed++;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    checks++; if (mem_req !== 1'b0 || mem_ack !== 1'b1) $display("FAIL rd0_rsp_c2 req/ack got=%b/%b exp=0/1", mem_req, mem_ack); else passed++;
    mem_recv = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_recv = 1'b0; mem_rdata = '0;
    checks++; if (bram_stall !== 1'b0) $display("FAIL rd0_stall_c3 got=%b exp=0", bram_stall); else passed++;
    checks++; if (mem_ack !== 1'b0) $display("FAIL rd0_ack_c3 got=%b exp=0", mem_ack); else passed++;
    bram_cen = 1'b0;
    step();
    checks++; if (bram_rdata !== 32'hDEAD_BEEF) $display("FAIL rd0_rdata_c4 got=%h exp=deadbeef", bram_rdata); else passed++;
    checks++; if (mem_req !== 1'b0) $display("FAIL rd0_no_rereq got=%b exp=0", mem_req); else passed++;
  endtask

  task automatic test_write_delayed_grant();
    run_txn(32'h20, 32'h1234_5678, 4'b0011, 5, 0, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0);
    checks++; if (r_wait !== 1) $display("FAIL wr_req_latency got=%0d exp=1", r_wait); else passed++;
    checks++; if (h_bad !== 0) $display("FAIL wr_req_hold_bad_cycles got=%0d exp=0", h_bad); else passed++;
    checks++; if (a_seen !== 32'h20 || d_seen !== 32'h1234_5678) $display("FAIL wr_addr_data got=%h/%h exp=00000020/12345678", a_seen, d_seen); else passed++;
    checks++; if (s_seen !== 4'b0011 || w_seen !== 1'b1) $display("FAIL wr_strb_wen got=%b/%b exp=0011/1", s_seen, w_seen); else passed++;
    checks++; if (r_bad !== 0) $display("FAIL wr_rsp_bad_cycles got=%0d exp=0", r_bad); else passed++;
    checks++; if (d_lat !== 1) $display("FAIL wr_accept_latency got=%0d exp=1", d_lat); else passed++;
    bram_cen = 1'b0;
    step();
    checks++; if (bram_rdata !== 32'hCAFE_F00D) $display("FAIL wr_rdata_capture got=%h exp=cafef00d", bram_rdata); else passed++;
    checks++; if (bram_error !== 1'b0) $display("FAIL wr_recv_outside_rsp got=%b exp=0", bram_error); else passed++;
  endtask

  task automatic test_delayed_response();
    run_txn(32'h44, 32'h0, 4'b0, 0, 7, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
    checks++; if (r_bad !== 0) $display("FAIL drsp_ack_hold_bad got=%0d exp=0", r_bad); else passed++;
    checks++; if (d_lat !== 1) $display("FAIL drsp_accept_latency got=%0d exp=1", d_lat); else passed++;
    bram_cen = 1'b0;
    step();
    checks++; if (bram_rdata !== 32'h0BAD_F00D) $display("FAIL drsp_rdata got=%h exp=0badf00d", bram_rdata); else passed++;
    step();
    checks++; if (mem_req !== 1'b0 || mem_ack !== 1'b0) $display("FAIL drsp_single_completion req/ack got=%b/%b exp=0/0", mem_req, mem_ack); else passed++;
  endtask

  task automatic test_error();
    run_txn(32'h400, 32'hAAAA_5555, 4'b1111, 0, 0, 32'hEEEE_0001, 1'b1, 1'b0, 1'b0);
    bram_cen = 1'b0;
    step();
    checks++; if (bram_error !== 1'b1) $display("FAIL err_set got=%b exp=1", bram_error); else passed++;
    checks++; if (bram_rdata !== 32'hEEEE_0001) $display("FAIL err_write_capture got=%h exp=eeee0001", bram_rdata); else passed++;
    run_txn(32'h404, 32'h0, 4'b0, 1, 1, 32'h0000_0404, 1'b0, 1'b0, 1'b0);
    bram_cen = 1'b0;
    step();
    checks++; if (bram_error !== 1'b1) $display("FAIL err_sticky got=%b exp=1", bram_error); else passed++;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (bram_error !== 1'b0) $display("FAIL err_clear got=%b exp=0", bram_error); else passed++;
    run_txn(32'h408, 32'h0, 4'b0, 0, 0, 32'h0000_0408, 1'b1, 1'b0, 1'b1);
    bram_cen = 1'b0;
    step();
    checks++; if (bram_error !== 1'b1) $display("FAIL err_set_beats_clear got=%b exp=1", bram_error); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] first_addr;
    int          first_wait;
    run_txn(32'h100, 32'h0, 4'b0, 0, 0, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    first_addr = a_seen; first_wait = r_wait;
    run_txn(32'h104, 32'h0, 4'b0, 0, 0, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
    checks++; if (first_addr !== 32'h100 || first_wait !== 1) $display("FAIL b2b_first addr/wait got=%h/%0d exp=00000100/1", first_addr, first_wait); else passed++;
    checks++; if (a_seen !== 32'h104 || r_wait !== 2) $display("FAIL b2b_second addr/wait got=%h/%0d exp=00000104/2", a_seen, r_wait); else passed++;
    bram_cen = 1'b0;
    step();
    checks++; if (bram_rdata !== 32'h2222_2222) $display("FAIL b2b_rdata got=%h exp=22222222", bram_rdata); else passed++;
  endtask

  task automatic test_reset_mid();
    bram_cen = 1'b1; bram_addr = 32'h200; bram_wstrb = 4'b0;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    checks++; if (mem_ack !== 1'b1) $display("FAIL rstmid_in_rsp got=%b exp=1", mem_ack); else passed++;
    g_reset = 1'b1; bram_cen = 1'b0;
    step();
    checks++; if (mem_ack !== 1'b0 || mem_req !== 1'b0) $display("FAIL rstmid_drop ack/req got=%b/%b exp=0/0", mem_ack, mem_req); else passed++;
    checks++; if (bram_rdata !== 32'h0 || bram_error !== 1'b0) $display("FAIL rstmid_regs rdata/err got=%h/%b exp=0/0", bram_rdata, bram_error); else passed++;
    g_reset = 1'b0;
    step();
    checks++; if (mem_req !== 1'b0 || mem_ack !== 1'b0) $display("FAIL rstmid_idle req/ack got=%b/%b exp=0/0", mem_req, mem_ack); else passed++;
  endtask

  task automatic test_cen_drop();
    bram_cen = 1'b1; bram_addr = 32'h300; bram_wstrb = 4'b0;
    step();
    bram_cen = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) $display("FAIL cdrop_req_kept req/addr got=%b/%h exp=1/00000300", mem_req, mem_addr); else passed++;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_recv = 1'b1; mem_rdata = 32'h5A5A_5A5A;
    step();
    mem_recv = 1'b0; mem_rdata = '0;
    step();
    step();
    checks++; if (mem_req !== 1'b0 || mem_ack !== 1'b0) $display("FAIL cdrop_no_new_req req/ack got=%b/%b exp=0/0", mem_req, mem_ack); else passed++;
    checks++; if (bram_rdata !== 32'h5A5A_5A5A) $display("FAIL cdrop_completed got=%h exp=5a5a5a5a", bram_rdata); else passed++;
  endtask

  task automatic test_timeout();
    int n;
    bram_cen = 1'b1; bram_addr = 32'h500; bram_wstrb = 4'b0;
    step();
    n = 0;
`ifdef IC_BRAM_BUS_BRIDGE_TIMEOUT_EN
    while (mem_req === 1'b1 && n < 200) begin
      n++;
      step();
    end
    checks++; if (n !== 4) $display("FAIL tmo_req_cycles got=%0d exp=4", n); else passed++;
    checks++; if (bram_error !== 1'b1) $display("FAIL tmo_error got=%b exp=1", bram_error); else passed++;
    checks++; if (bram_rdata !== 32'h0) $display("FAIL tmo_rdata got=%h exp=0", bram_rdata); else passed++;
    checks++; if (bram_stall !== 1'b0) $display("FAIL tmo_accept got=%b exp=0", bram_stall); else passed++;
    bram_cen = 1'b0;
    step();
`else
    while (mem_req === 1'b1 && n < 120) begin
      n++;
      step();
    end
    checks++; if (n !== 120) $display("FAIL notmo_req_held got=%0d exp=120", n); else passed++;
    checks++; if (bram_error !== 1'b0 || bram_stall !== 1'b1) $display("FAIL notmo_state err/stall got=%b/%b exp=0/1", bram_error, bram_stall); else passed++;
    g_reset = 1'b1; bram_cen = 1'b0;
    step();
    g_reset = 1'b0;
    step();
    checks++; if (mem_req !== 1'b0) $display("FAIL notmo_reset_abort got=%b exp=0", mem_req); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_delayed_grant();
    test_delayed_response();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_cen_drop();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
